// File: rtl/arb_mux.sv
// Round-robin arbitrating multiplexer: CH valid/ready request streams merged onto
// one registered output stage, with multi-beat bursts locked to their owner.
module arb_mux #(
    parameter  int N  = 32,
    parameter  int CH = 2,
    localparam int CW = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [CH-1:0]     req_valid,
    input  logic [CH-1:0]     req_last,
    input  logic [CH*N-1:0]   req_data,
    output logic [CH-1:0]     req_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic              out_last,
    output logic [CW-1:0]     out_ch,
    input  logic              out_ready
);

    logic [CW-1:0]   ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   owner_q, owner_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [CW-1:0]   out_ch_q, out_ch_d;

    logic [2*CH-1:0] rot_s;
    logic            search_vld_s;
    logic [CW-1:0]   search_idx_s;
    logic            owner_hit_s;
    logic            grant_vld_s;
    logic [CW-1:0]   grant_idx_s;
    logic [N-1:0]    grant_data_s;
    logic            grant_last_s;
    logic            can_load_s;
    logic            accept_s;
    logic [CW-1:0]   nxt_ptr_s;

    // Grant selection: rotating search from ptr, or owner only while locked.
    always_comb begin
        logic [CW:0] sum;
        sum          = '0;
        rot_s        = {req_valid, req_valid} >> ptr_q;
        search_vld_s = 1'b0;
        search_idx_s = '0;
        owner_hit_s  = 1'b0;
        // Walk from the far end so the candidate closest to ptr wins.
        for (int k = CH - 1; k >= 0; k--) begin
            sum          = {1'b0, ptr_q} + (CW+1)'(k);
            sum          = (sum >= (CW+1)'(CH)) ? sum - (CW+1)'(CH) : sum;
            search_idx_s = rot_s[k] ? sum[CW-1:0] : search_idx_s;
            search_vld_s = search_vld_s | rot_s[k];
        end
        for (int i = 0; i < CH; i++) begin
            owner_hit_s = owner_hit_s | (req_valid[i] & (owner_q == CW'(i)));
        end
        grant_vld_s = lock_q ? owner_hit_s : search_vld_s;
        grant_idx_s = lock_q ? owner_q : search_idx_s;
    end

    // Handshake and the data/last mux of the granted channel.
    always_comb begin
        can_load_s   = !out_valid_q || out_ready;
        accept_s     = resetn && can_load_s && grant_vld_s;
        grant_data_s = '0;
        grant_last_s = 1'b0;
        req_ready    = '0;
        for (int i = 0; i < CH; i++) begin
            grant_data_s = grant_data_s | (req_data[i*N +: N] & {N{grant_idx_s == CW'(i)}});
            grant_last_s = grant_last_s | (req_last[i] & (grant_idx_s == CW'(i)));
            req_ready[i] = accept_s && (grant_idx_s == CW'(i));
        end
        nxt_ptr_s = (grant_idx_s == CW'(CH - 1)) ? '0 : grant_idx_s + CW'(1);
    end

    // Next state of the arbitration state and output register.
    always_comb begin
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_last_d  = grant_last_s;
            out_ch_d    = grant_idx_s;
            if (grant_last_s) begin
                lock_d = 1'b0;
                ptr_d  = nxt_ptr_s;
            end else begin
                lock_d  = 1'b1;
                owner_d = grant_idx_s;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (CH=3): directed scenarios plus random traffic, all checked
// against a transaction-level model of the round-robin / burst-lock rules.
module tb_arb_mux;
    localparam int N  = 32;
    localparam int CH = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [CH-1:0]   req_valid;
    logic [CH-1:0]   req_last;
    logic [CH*N-1:0] req_data;
    logic [CH-1:0]   req_ready;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic            out_last;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    always #5 clk = ~clk;

    arb_mux #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_ptr, m_owner, m_och;
    bit           m_lock, m_ov, m_ol;
    logic [N-1:0] m_od;

    // Values observed at the last sampling point
    logic [CH-1:0] s_rr;
    logic          s_ov;
    logic [N-1:0]  s_od;
    logic [CW-1:0] s_och;
    logic [N-1:0]  seen[$];
    int            chs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic void model_grant(output bit f, output int g);
        f = 1'b0;
        g = 0;
        if (m_lock) begin
            f = req_valid[m_owner];
            g = m_owner;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (!f && req_valid[(m_ptr + k) % CH]) begin
                    f = 1'b1;
                    g = (m_ptr + k) % CH;
                end
            end
        end
    endfunction

    task automatic set_ch(input int c, input bit v, input bit l, input logic [N-1:0] d);
        req_valid[c]       = v;
        req_last[c]        = l;
        req_data[c*N +: N] = d;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit            f;
        int            g;
        bit            can;
        logic [CH-1:0] er;
        @(negedge clk);
        model_grant(f, g);
        can = !m_ov || out_ready;
        er  = '0;
        if (can && f) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data",  64'(out_data),  64'(m_od));
        chk("out_last",  64'(out_last),  64'(m_ol));
        chk("out_ch",    64'(out_ch),    64'(m_och));
        s_rr  = req_ready;
        s_ov  = out_valid;
        s_od  = out_data;
        s_och = out_ch;
        if (out_valid && out_ready) begin
            seen.push_back(out_data);
            chs.push_back(int'(out_ch));
        end
        @(posedge clk);
        #1;
        if (can && f) begin
            m_ov  = 1'b1;
            m_od  = req_data[g*N +: N];
            m_ol  = req_last[g];
            m_och = g;
            if (req_last[g]) begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % CH;
            end else begin
                m_lock  = 1'b1;
                m_owner = g;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_ch",    64'(out_ch),    64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        m_ptr = 0; m_owner = 0; m_och = 0; m_lock = 0; m_ov = 0; m_ol = 0; m_od = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int beat;
        int guard;
        bit got1;
        logic [N-1:0] burst_exp [5];
        int rr_exp [6];
        resetn    = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        #3;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            out_ready = i[0];
            step();
        end

        // Single beat from channel 1, then pointer must have wrapped past it
        out_ready = 1'b1;
        set_ch(1, 1'b1, 1'b1, 32'hDEADBEEF);
        step();
        chk("single_ready", 64'(s_rr), 64'(3'b010));
        set_ch(1, 1'b0, 1'b0, 32'h0);
        step();
        chk("single_valid", 64'(s_ov), 64'(1));
        chk("single_data",  64'(s_od), 64'(32'hDEADBEEF));
        chk("single_ch",    64'(s_och), 64'(1));
        set_ch(0, 1'b1, 1'b1, 32'h0A);
        set_ch(1, 1'b1, 1'b1, 32'h1A);
        step();
        chk("ptr_after_ch1", 64'(s_rr), 64'(3'b001));
        clear_inputs();
        step();
        step();

        // Round-robin with all three channels busy
        do_reset();
        for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 1'b1, 32'h100 + 32'(c));
        chs.delete();
        for (int i = 0; i < 7; i++) step();
        rr_exp = '{0, 1, 2, 0, 1, 2};
        chk("rr_count", 64'(chs.size() >= 6), 64'(1));
        for (int i = 0; i < 6; i++) begin
            if (i < chs.size()) chk("rr_order", 64'(chs[i]), 64'(rr_exp[i]));
        end
        clear_inputs();
        step();

        // Four-beat burst on ch0 while ch1 waits
        do_reset();
        set_ch(1, 1'b1, 1'b1, 32'hB1);
        seen.delete();
        beat  = 0;
        guard = 0;
        while (beat < 4 && guard < 40) begin
            set_ch(0, 1'b1, beat == 3, 32'h10 + 32'(beat));
            step();
            if (s_rr[0]) beat++;
            guard++;
        end
        chk("burst_beats", 64'(beat), 64'(4));
        set_ch(0, 1'b0, 1'b0, 32'h0);
        got1 = 1'b0;
        for (int i = 0; i < 10 && !got1; i++) begin
            step();
            got1 = s_rr[1];
        end
        chk("burst_ch1_grant", 64'(got1), 64'(1));
        set_ch(1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        burst_exp = '{32'h10, 32'h11, 32'h12, 32'h13, 32'hB1};
        chk("burst_count", 64'(seen.size() >= 5), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) chk("burst_order", 64'(seen[i]), 64'(burst_exp[i]));
        end

        // Backpressure with a held beat
        do_reset();
        set_ch(0, 1'b1, 1'b1, 32'hA0);
        step();
        out_ready = 1'b0;
        set_ch(0, 1'b1, 1'b1, 32'hA1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 64'(s_rr), 64'(0));
            chk("bp_hold",  64'(s_od), 64'(32'hA0));
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", 64'(s_rr), 64'(3'b001));
        clear_inputs();
        step();
        step();

        // Async reset in the middle of a locked ch1 burst
        do_reset();
        set_ch(1, 1'b1, 1'b0, 32'hC0);
        step();
        set_ch(1, 1'b1, 1'b0, 32'hC1);
        step();
        chk("mid_lock_beats", 64'(s_rr), 64'(3'b010));
        do_reset();
        set_ch(0, 1'b1, 1'b1, 32'hD0);
        set_ch(1, 1'b1, 1'b1, 32'hD1);
        step();
        chk("post_reset_grant", 64'(s_rr), 64'(3'b001));
        clear_inputs();
        step();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < CH; c++) begin
                set_ch(c, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom);
            end
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 199) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-bit, CH-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes, the sequential successor to the core's two-input combinational select. It merges request streams from several CPU-side sources (e.g. instruction fetch, data access, uncached store path) onto one downstream channel toward the AXI bridge. Selection is round-robin, multi-beat bursts are never interleaved, and the output is fully registered to cut the combinational path to the bridge.

## Interface
- N, 32, data width per channel
- CH, 2, number of input channels (≥2); CW = max(1, clog2(CH)) is the index width
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  CH  per-channel request valid
- req_last  in  CH  per-channel last-beat flag; 0 keeps the channel locked after acceptance
- req_data  in  CH*N  channel i data at [i*N +: N]
- req_ready  out  CH  per-channel accept; one-hot or zero
- out_valid  out  1  output register holds a beat
- out_data  out  N  registered beat data
- out_last  out  1  registered last flag
- out_ch  out  CW  source channel of the held beat
- out_ready  in  1  downstream accept

## Operation
- State: ptr (CW bits, round-robin start), lock (1 bit), owner (CW bits), output register {out_valid, out_data, out_last, out_ch}.
- can_load = !out_valid || out_ready.
- Grant when lock=0: first i with req_valid[i]=1, searching ptr, ptr+1, …, CH-1, 0, …, ptr-1 (modulo CH). No valid request means no grant.
- Grant when lock=1: owner only, and only if req_valid[owner]=1; other channels wait even if owner is idle.
- req_ready[g] = can_load && granted(g); all other bits are 0. req_ready depends combinationally on req_valid, lock, owner, ptr, out_valid and out_ready; it never depends on req_data.
- On acceptance of channel g: out_data←req_data[g], out_last←req_last[g], out_ch←g, out_valid←1.
- If req_last[g]=0: lock←1, owner←g, ptr unchanged.
- If req_last[g]=1: lock←0, ptr←(g+1) mod CH.
- If out_valid && out_ready and there is no acceptance: out_valid←0. The data registers hold their values.
- While out_valid=1 && out_ready=0, all output registers are stable.
- Non-power-of-two CH: index arithmetic wraps at CH, not 2^CW. Indices ≥CH are never produced.

## Timing
- Reset (resetn=0, async): out_valid=0, out_data=0, out_last=0, out_ch=0, ptr=0, lock=0, owner=0. req_ready=0 while resetn=0.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous drain and load (out_valid && out_ready && acceptance): out_valid stays 1 and the register takes the new beat. There is no bubble.
- Full (out_valid=1, out_ready=0): req_ready=0 on all channels.
- Reset mid-burst: lock clears, the held beat is discarded, and arbitration restarts at channel 0.
- A requester may drop req_valid before acceptance. Arbitration re-evaluates every cycle; no grant is latched.

## Test plan
- Reset/idle: resetn low, then high with no requests -> all outputs 0, req_ready=0.
- Single beat, CH=2: ch1 valid, data 0xDEADBEEF, last=1, out_ready=1 -> req_ready=2'b10 in cycle t; in t+1 out_valid=1, out_data=0xDEADBEEF, out_ch=1, out_last=1; ptr→0.
- Round-robin fairness, CH=3: all channels continuously valid with last=1, out_ready=1 -> out_ch sequence 0,1,2,0,1,2 at one beat per cycle.
- Burst lock, CH=2: ch0 sends 4 beats 0x10..0x13 (last only on beat 4) while ch1 is valid throughout -> out_data 0x10,0x11,0x12,0x13 then ch1's beat. No interleave.
- Backpressure: out_ready=0 for 3 cycles with a beat held and ch0 valid -> out_* stable, req_ready=0. Then out_ready=1 -> the next beat loads the same cycle.
- Async reset mid-burst: resetn pulsed low after beat 2 of a locked ch1 burst -> out_valid=0 immediately. After release with both channels valid, ch0 is granted first.
